// File: rtl/sigma_delta_dac.sv
// Sigma-delta DAC: one-entry sample buffer, STGS-stage CIC interpolator (xBOSR) and a
// first-order error-feedback modulator driving a 1-bit PDM pin.
module sigma_delta_dac #(
    parameter int unsigned BOSR = 256,
    parameter int unsigned STGS = 2,
    parameter int unsigned WDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WDTH-1:0] dac_input,
    input  logic            dac_valid,
    output logic            dac_ready,
    output logic            dac_pin,
    output logic            dac_underrun
);
    localparam int unsigned LB = $clog2(BOSR);
    localparam int unsigned IW = WDTH + STGS * LB;
    localparam int unsigned SH = (STGS - 1) * LB;

    logic [LB-1:0]   r_phase;
    logic            r_buf_full;
    logic [WDTH-1:0] r_buf;
    logic [WDTH-1:0] r_held;
    logic            r_ready;

    logic            w_tick;
    logic            w_accept;
    logic            w_buf_full_d;
    logic [WDTH-1:0] w_held_d;

    assign w_tick       = (r_phase == LB'(BOSR - 1));
    assign w_accept     = dac_valid & r_ready;
    // A tick always sees the buffer as it was before this cycle's accept: no bypass.
    assign w_buf_full_d = w_accept | (r_buf_full & ~w_tick);
    assign w_held_d     = (w_tick & r_buf_full) ? r_buf : r_held;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase    <= '0;
            r_buf_full <= 1'b0;
            r_buf      <= '0;
            r_held     <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_phase    <= r_phase + LB'(1);
            r_buf_full <= w_buf_full_d;
            if (w_accept) begin
                r_buf <= dac_input;
            end
            r_held     <= w_held_d;
            r_ready    <= ~w_buf_full_d;
        end
    end

    assign dac_ready    = r_ready;
    assign dac_underrun = w_tick & ~r_buf_full;

    logic [IW-1:0] r_comb_prev [STGS];
    logic [IW-1:0] r_comb_out;
    logic          r_tick_q;
    logic [IW-1:0] w_comb_in   [STGS];
    logic [IW-1:0] w_comb_last;

    // Comb chain runs at the sample rate on the value entering the held register.
    always_comb begin
        logic [IW-1:0] v_run;
        v_run = IW'(w_held_d);
        for (int k = 0; k < int'(STGS); k++) begin
            w_comb_in[k] = v_run;
            v_run        = v_run - r_comb_prev[k];
        end
        w_comb_last = v_run;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(STGS); k++) begin
                r_comb_prev[k] <= '0;
            end
            r_comb_out <= '0;
            r_tick_q   <= 1'b0;
        end else begin
            r_tick_q <= w_tick;
            if (w_tick) begin
                for (int k = 0; k < int'(STGS); k++) begin
                    r_comb_prev[k] <= w_comb_in[k];
                end
                r_comb_out <= w_comb_last;
            end
        end
    end

    logic [IW-1:0] r_integ    [STGS];
    logic [IW-1:0] w_integ_in [STGS];

    // Zero stuffing: the comb result enters the integrators once per sample period.
    always_comb begin
        for (int k = 0; k < int'(STGS); k++) begin
            w_integ_in[k] = '0;
        end
        w_integ_in[0] = r_tick_q ? r_comb_out : '0;
        for (int k = 1; k < int'(STGS); k++) begin
            w_integ_in[k] = r_integ[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(STGS); k++) begin
                r_integ[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STGS); k++) begin
                r_integ[k] <= r_integ[k] + w_integ_in[k];
            end
        end
    end

    logic [IW-1:0]   w_shifted;
    logic [WDTH-1:0] w_y;

    assign w_shifted = r_integ[STGS-1] >> SH;
    assign w_y       = (w_shifted > IW'({WDTH{1'b1}})) ? {WDTH{1'b1}} : w_shifted[WDTH-1:0];

    logic [WDTH-1:0] r_acc;
    logic            r_pin;
    logic [WDTH:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, w_y};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_pin <= 1'b0;
        end else begin
            r_acc <= w_sum[WDTH-1:0];
            r_pin <= w_sum[WDTH];
        end
    end

    assign dac_pin = r_pin;

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Directed bench for sigma_delta_dac at WDTH=8, BOSR=16, STGS=2; outputs sampled on negedge.
module tb_sigma_delta_dac;
    localparam int unsigned WDTH = 8;
    localparam int unsigned BOSR = 16;
    localparam int unsigned STGS = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [WDTH-1:0] dac_input = '0;
    logic            dac_valid = 1'b0;
    logic            dac_ready;
    logic            dac_pin;
    logic            dac_underrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference phase: tick cycles are those sampled with ph == 15.
    logic [3:0] ph;

    sigma_delta_dac #(
        .BOSR(BOSR),
        .STGS(STGS),
        .WDTH(WDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dac_input   (dac_input),
        .dac_valid   (dac_valid),
        .dac_ready   (dac_ready),
        .dac_pin     (dac_pin),
        .dac_underrun(dac_underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) ph <= 4'd0;
        else     ph <= ph + 4'd1;
    end

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (dac_ready && dac_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ph == 4'd15) break;
        end
    endtask

    task automatic test_reset();
        int ones, und, bad;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dac_pin !== 1'b0) begin n_fail++; $display("FAIL reset_pin: got %b want 0", dac_pin); end
        n_checks++;
        if (dac_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", dac_ready); end
        n_checks++;
        if (dac_underrun !== 1'b0) begin
            n_fail++; $display("FAIL reset_underrun: got %b want 0", dac_underrun);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (dac_ready !== 1'b0) begin n_fail++; $display("FAIL ready_pre_edge: got %b want 0", dac_ready); end
        @(negedge clk);
        n_checks++;
        if (dac_ready !== 1'b1) begin n_fail++; $display("FAIL ready_first_edge: got %b want 1", dac_ready); end
        ones = 0; und = 0; bad = 0;
        repeat (64) begin
            @(negedge clk);
            ones += int'(dac_pin);
            und  += int'(dac_underrun);
            if (dac_underrun !== (ph == 4'd15)) bad++;
        end
        n_checks++;
        if (ones != 0) begin n_fail++; $display("FAIL idle_pin_ones: got %0d want 0", ones); end
        n_checks++;
        if (und != 4) begin n_fail++; $display("FAIL idle_underrun_count: got %0d want 4", und); end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL idle_underrun_timing: got %0d bad want 0", bad); end
    endtask

    // Step 0 -> 255 from the reset state (modulator accumulator is zero).
    task automatic test_step();
        int p [0:56];
        int w, prev, first_e, decr, early;
        @(negedge clk);
        dac_input = 8'd255;
        dac_valid = 1'b1;
        n_checks++;
        if (dac_ready !== 1'b1) begin n_fail++; $display("FAIL step_ready: got %b want 1", dac_ready); end
        wait_tick();
        p[0] = int'(dac_pin);
        for (int i = 1; i <= 56; i++) begin
            @(negedge clk);
            p[i] = int'(dac_pin);
        end
        prev = 0; first_e = -1; decr = 0;
        for (int e = 1; e <= 56; e++) begin
            w = 0;
            for (int j = e - 15; j <= e; j++) if (j >= 0) w += p[j];
            if (w < prev) decr++;
            if (w >= 15 && first_e < 0) first_e = e;
            prev = w;
        end
        early = p[0] + p[1] + p[2] + p[3];
        n_checks++;
        if (early != 0) begin n_fail++; $display("FAIL step_early_ones: got %0d want 0", early); end
        n_checks++;
        if (decr != 0) begin n_fail++; $display("FAIL step_monotonic: got %0d drops want 0", decr); end
        n_checks++;
        if (first_e < 18 || first_e > 36) begin
            n_fail++; $display("FAIL step_settle: got %0d want 18..36", first_e);
        end
    endtask

    task automatic test_full_scale();
        int ones;
        repeat (32) @(negedge clk);
        ones = 0;
        repeat (256) begin
            @(negedge clk);
            ones += int'(dac_pin);
        end
        n_checks++;
        if (ones != 255) begin n_fail++; $display("FAIL full_scale_ones: got %0d want 255", ones); end
    endtask

    task automatic test_zero_and_half();
        bit ok0, ok1;
        int ones0, ones, bad;
        logic prev_pin;
        wait_accept(ok0);
        @(negedge clk);
        dac_input = 8'd0;
        repeat (80) @(negedge clk);
        ones0 = 0;
        repeat (64) begin
            @(negedge clk);
            ones0 += int'(dac_pin);
        end
        wait_accept(ok1);
        @(negedge clk);
        dac_input = 8'd128;
        repeat (80) @(negedge clk);
        prev_pin = dac_pin;
        ones = 0; bad = 0;
        repeat (256) begin
            @(negedge clk);
            if (dac_pin === prev_pin) bad++;
            prev_pin = dac_pin;
            ones += int'(dac_pin);
        end
        n_checks++;
        if (!(ok0 && ok1)) begin n_fail++; $display("FAIL switch_accept: got %b%b want 11", ok0, ok1); end
        n_checks++;
        if (ones0 != 0) begin n_fail++; $display("FAIL zero_ones: got %0d want 0", ones0); end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL half_alternate: got %0d repeats want 0", bad); end
        n_checks++;
        if (ones != 128) begin n_fail++; $display("FAIL half_ones: got %0d want 128", ones); end
    endtask

    task automatic test_async_reset();
        bit found;
        int ones;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (dac_pin === 1'b1) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL async_pin_high: got 0 want 1"); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dac_pin !== 1'b0) begin n_fail++; $display("FAIL async_pin: got %b want 0", dac_pin); end
        n_checks++;
        if (dac_ready !== 1'b0) begin n_fail++; $display("FAIL async_ready: got %b want 0", dac_ready); end
        n_checks++;
        if (dac_underrun !== 1'b0) begin
            n_fail++; $display("FAIL async_underrun: got %b want 0", dac_underrun);
        end
        dac_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (dac_ready !== 1'b0) begin n_fail++; $display("FAIL held_ready: got %b want 0", dac_ready); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dac_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", dac_ready); end
        ones = 0;
        repeat (32) begin
            @(negedge clk);
            ones += int'(dac_pin);
        end
        n_checks++;
        if (ones != 0) begin n_fail++; $display("FAIL release_pin_ones: got %0d want 0", ones); end
    endtask

    task automatic test_handshake();
        bit pend;
        int accepts, rdy_bad, und;
        pend = 1'b0; accepts = 0; rdy_bad = 0; und = 0;
        @(negedge clk);
        dac_input = 8'd0;
        dac_valid = 1'b1;
        for (int i = 0; i < 192; i++) begin
            if (pend) begin
                dac_input = dac_input + 8'd1;
                pend = 1'b0;
            end
            if (dac_ready && dac_valid) begin
                pend = 1'b1;
                if (i >= 32) accepts++;
            end
            if (i >= 32) begin
                if (dac_ready !== (ph == 4'd0)) rdy_bad++;
                und += int'(dac_underrun);
            end
            @(negedge clk);
        end
        n_checks++;
        if (accepts != 10) begin n_fail++; $display("FAIL hs_accepts: got %0d want 10", accepts); end
        n_checks++;
        if (rdy_bad != 0) begin n_fail++; $display("FAIL hs_ready_timing: got %0d bad want 0", rdy_bad); end
        n_checks++;
        if (und != 0) begin n_fail++; $display("FAIL hs_underrun: got %0d want 0", und); end
    endtask

    task automatic test_underrun();
        bit ok;
        int cnt, bad, pulses, ones, und;
        wait_accept(ok);
        @(negedge clk);
        dac_input = 8'd64;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (dac_ready && dac_valid) begin
                cnt++;
                if (cnt == 10) break;
            end
        end
        n_checks++;
        if (!ok || cnt != 10) begin n_fail++; $display("FAIL ur_feed: got %0d want 10", cnt); end
        @(negedge clk);
        dac_valid = 1'b0;
        wait_tick();
        n_checks++;
        if (dac_underrun !== 1'b0) begin n_fail++; $display("FAIL ur_last_load: got %b want 0", dac_underrun); end
        bad = 0; pulses = 0;
        repeat (64) begin
            @(negedge clk);
            if (dac_underrun !== (ph == 4'd15)) bad++;
            pulses += int'(dac_underrun);
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL ur_timing: got %0d bad want 0", bad); end
        n_checks++;
        if (pulses != 4) begin n_fail++; $display("FAIL ur_pulses: got %0d want 4", pulses); end
        ones = 0;
        repeat (256) begin
            @(negedge clk);
            ones += int'(dac_pin);
        end
        n_checks++;
        if (ones != 64) begin n_fail++; $display("FAIL ur_density: got %0d want 64", ones); end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ph == 4'd0) break;
        end
        dac_valid = 1'b1;
        und = 0;
        repeat (48) begin
            @(negedge clk);
            und += int'(dac_underrun);
        end
        n_checks++;
        if (und != 0) begin n_fail++; $display("FAIL ur_resume: got %0d want 0", und); end
    endtask

    task automatic test_same_cycle();
        bit ok;
        int ones;
        wait_accept(ok);
        @(negedge clk);
        dac_valid = 1'b0;
        wait_tick();
        wait_tick();
        dac_input = 8'd192;
        dac_valid = 1'b1;
        n_checks++;
        if (!ok || dac_underrun !== 1'b1) begin
            n_fail++; $display("FAIL sc_underrun: got %b want 1", dac_underrun);
        end
        n_checks++;
        if (dac_ready !== 1'b1) begin n_fail++; $display("FAIL sc_ready: got %b want 1", dac_ready); end
        ones = 0;
        for (int idx = 1; idx <= 19; idx++) begin
            @(negedge clk);
            if (idx == 1) begin
                n_checks++;
                if (dac_ready !== 1'b0) begin
                    n_fail++; $display("FAIL sc_accepted: got %b want 0", dac_ready);
                end
            end
            if (idx == 16) begin
                n_checks++;
                if (dac_underrun !== 1'b0) begin
                    n_fail++; $display("FAIL sc_next_tick: got %b want 0", dac_underrun);
                end
            end
            if (idx == 17) begin
                n_checks++;
                if (dac_ready !== 1'b1) begin
                    n_fail++; $display("FAIL sc_ready_return: got %b want 1", dac_ready);
                end
            end
            if (idx >= 4) ones += int'(dac_pin);
        end
        n_checks++;
        if (ones != 4) begin n_fail++; $display("FAIL sc_old_density: got %0d want 4", ones); end
        dac_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_full_scale();
        test_zero_and_half();
        test_async_reset();
        test_handshake();
        test_underrun();
        test_same_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sigma_delta_dac.md
Name: sigma_delta_dac

Overview:
Sigma-delta DAC: the transmit-side counterpart of sigma_delta_adc. It accepts unsigned offset-binary PCM samples at the sample rate (clk/BOSR) over a valid/ready handshake. A STGS-stage CIC interpolator upsamples each sample by BOSR, and a first-order error-feedback modulator drives a 1-bit PDM pin. The pin feeds an external RC low-pass, whose output voltage is VCC * density of ones.

Parameters:
BOSR, 256, oversampling ratio (clocks per sample); must be a power of two >= 4; LB = log2(BOSR)
STGS, 2, CIC interpolator order (comb and integrator stage count); 1..4
WDTH, 16, input sample width; 0 = zero scale, 2^WDTH-1 = full scale

Ports:
clk  in  1  bit clock, BOSR * sample rate
rst  in  1  asynchronous active-high reset
dac_input  in  WDTH  unsigned PCM sample
dac_valid  in  1  dac_input holds a sample
dac_ready  out  1  one-entry input buffer is empty; a sample is accepted when dac_valid && dac_ready at posedge clk
dac_pin  out  1  PDM output to the external integrator
dac_underrun  out  1  one-cycle pulse when a sample slot finds the buffer empty

Behaviour:
- Reset (async, any time including mid-operation):
  - dac_pin=0, dac_ready=0, dac_underrun=0.
  - Phase counter=0, buffer empty, held sample=0, all comb/integrator/modulator state=0.
  - dac_ready rises on the first clk edge after rst deasserts.
- Phase counter: 0..BOSR-1, wraps. Tick = (counter == BOSR-1), one cycle in BOSR.
- Input buffer (one entry):
  - Accept: buffer loads dac_input and becomes full; dac_ready is registered and drops the next cycle.
  - On tick with a full buffer: the sample moves to the held register, the buffer empties, and dac_ready returns the next cycle.
  - On tick with an empty buffer: the held sample repeats and dac_underrun pulses for that cycle.
  - Accept and tick in the same cycle with an empty buffer: the tick sees empty (underrun), and the accepted sample waits for the next tick. No bypass path.
  - dac_valid while dac_ready=0 is ignored; upstream holds dac_valid/dac_input until accepted.
- CIC interpolator, IW = WDTH + STGS*LB bits, all arithmetic modulo 2^IW (wrap is intentional, no saturation inside):
  - Comb stages update on tick only: c_k = in_k - prev_k, with stage-0 input = zero-extended held sample.
  - Integrator stages update every clk; the first integrator's input is the last comb output on the cycle after tick and 0 otherwise (zero stuffing).
  - Scaled output y = last integrator >> ((STGS-1)*LB), clamped to 2^WDTH-1 if larger.
  - The CIC step response is monotonic, so the clamp is a guard only.
- Modulator:
  - sum = acc + y (WDTH+1 bits); acc <= sum[WDTH-1:0]; dac_pin <= sum[WDTH] (registered).
  - Ones density = y/2^WDTH exactly over any 2^WDTH clocks at constant y.
- Latency: after a sample is loaded at tick, y reaches its final value within STGS*BOSR + STGS + 2 clocks and moves monotonically toward it.
- No other outputs. dac_pin changes only on clk edges or at reset.

Test Plan:
All scenarios use WDTH=8, BOSR=16, STGS=2 unless noted.
1. Reset: assert rst mid-stream, asynchronously between edges -> dac_pin, dac_ready, dac_underrun go 0 immediately. After release, dac_ready=1 on the first edge, and the pin stays 0 until a nonzero sample is loaded.
2. Constant 0, then constant 128 fed continuously -> with 0, dac_pin is 0 always. With 128, after 40 clocks of settle, dac_pin strictly alternates, giving 128 ones in any 256 consecutive clocks.
3. Full scale 255 continuous -> after settle, exactly 255 ones per 256 clocks. Zero-scale-to-full-scale step: the moving 16-clock density is non-decreasing, and it reaches 15 or 16 within 36 clocks of the loading tick.
4. Handshake: dac_valid held high with an incrementing sample -> exactly one accept per 16 clocks. dac_ready is low from the cycle after accept until the cycle after tick, and no sample is skipped or duplicated (checked via the y monitor).
5. Underrun: feed 64 for 10 samples, then drop dac_valid -> dac_underrun pulses once every 16 clocks, on the tick cycle only. Density holds at 64/256. Re-asserting dac_valid stops the pulses from the next tick.
6. Same-cycle accept plus tick with an empty buffer -> dac_underrun=1 that cycle. The new sample loads at the following tick, not the current one.
